pipe_credit_scheduler: RTL and testbench

- Flow-control front end for a fixed-latency, non-stallable pipeline stage of depth LATENCY.
- Accepts valid/ready input and issues at most one beat per cycle into the external pipeline.
- Captures the returned beats in an internal FIFO of DEPTH entries.
- Presents FIFO contents on a valid/ready output.
- Credit counting guarantees that every beat in flight has a reserved FIFO slot, so the pipeline never needs to stall.

---
 rtl/pipe_credit_scheduler.sv | 144 ++++++++++++++
 tb/tb_pipe_credit_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_scheduler.sv
// Credit-based issue front end for a fixed-latency, non-stallable pipeline with a FWFT return FIFO.
// Optional macro PIPE_SCHED_LATENCY_CHECK_EN adds a shadow shift register that flags early/missing returns.
module pipe_credit_scheduler #(
  parameter int LATENCY = 3,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         s_valid_in,
  output logic                         s_ready_out,
  input  logic [WIDTH-1:0]             s_data_in,
  output logic                         issue_valid_out,
  output logic [WIDTH-1:0]             issue_data_out,
  input  logic                         ret_valid_in,
  input  logic [WIDTH-1:0]             ret_data_in,
  output logic                         m_valid_out,
  input  logic                         m_ready_in,
  output logic [WIDTH-1:0]             m_data_out,
  output logic [$clog2(DEPTH+1)-1:0]   credits_out,
  output logic                         err_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(LATENCY + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [DW-1:0] LAT_C    = DW'(LATENCY);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic {DRAIN, RUN} state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    drain_reg, drain_next;
  logic [CW-1:0]    credits_reg, credits_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] mem [DEPTH];

  logic run, fire, pop, write, wr_accept, overflow, credit_over, lat_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign run             = (state_reg == RUN);
  assign s_ready_out     = run & (credits_reg != '0);
  assign fire            = s_valid_in & s_ready_out;
  assign issue_valid_out = fire;
  assign issue_data_out  = s_data_in;
  assign m_valid_out     = (count_reg != '0);
  assign m_data_out      = mem[rd_ptr_reg];
  assign pop             = m_valid_out & m_ready_in;
  assign credits_out     = credits_reg;
  assign err_out         = err_reg;

  // Returns are only meaningful once the pre-reset pipeline contents have drained out.
  assign write     = run & ret_valid_in;
  assign overflow  = write & (count_reg == DEPTH_C) & ~pop;
  assign wr_accept = write & ~overflow;

`ifdef PIPE_SCHED_LATENCY_CHECK_EN
  logic [LATENCY-1:0] shadow_reg;
  logic [LATENCY:0]   shadow_shift;

  assign shadow_shift = {shadow_reg, fire};
  assign lat_err      = run & (ret_valid_in != shadow_reg[LATENCY-1]);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_reg <= '0;
    end else begin
      shadow_reg <= shadow_shift[LATENCY-1:0];
    end
  end
`else
  assign lat_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    drain_next = drain_reg;
    if (state_reg == DRAIN) begin
      if (drain_reg != '0) drain_next = drain_reg - DW'(1);
      if (drain_reg <= DW'(1)) state_next = RUN;
    end
  end

  always_comb begin
    credits_next = credits_reg;
    credit_over  = 1'b0;
    case ({fire, pop})
      2'b10: credits_next = credits_reg - CW'(1);
      2'b01: begin
        if (credits_reg == DEPTH_C) credit_over = 1'b1;
        else                        credits_next = credits_reg + CW'(1);
      end
      default: credits_next = credits_reg;
    endcase
  end

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_accept) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)       rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({wr_accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    err_next = err_reg | overflow | credit_over | lat_err;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= DRAIN;
      drain_reg   <= LAT_C;
      credits_reg <= DEPTH_C;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      drain_reg   <= drain_next;
      credits_reg <= credits_next;
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      err_reg     <= err_next;
    end
  end

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk_in) begin
    if (wr_accept) mem[wr_ptr_reg] <= ret_data_in;
  end

endmodule

// File: tb/tb_pipe_credit_scheduler.sv
// Bench for pipe_credit_scheduler: hand-derived vector table, directed corner sequences and
// randomized traffic against a queue-based reference model with an external LATENCY-deep pipeline.
`timescale 1ns/1ps
module tb_pipe_credit_scheduler;
  localparam int LAT = 3;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int CW  = $clog2(D + 1);

  logic          clk_in = 1'b0;
  logic          rst_in, s_valid_in, s_ready_out, issue_valid_out;
  logic          ret_valid_in, m_valid_out, m_ready_in, err_out;
  logic [W-1:0]  s_data_in, issue_data_out, ret_data_in, m_data_out;
  logic [CW-1:0] credits_out;

  always #5 clk_in = ~clk_in;

  pipe_credit_scheduler #(.LATENCY(LAT), .WIDTH(W), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_valid_in(s_valid_in), .s_ready_out(s_ready_out), .s_data_in(s_data_in),
    .issue_valid_out(issue_valid_out), .issue_data_out(issue_data_out),
    .ret_valid_in(ret_valid_in), .ret_data_in(ret_data_in),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .m_data_out(m_data_out),
    .credits_out(credits_out), .err_out(err_out)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // External pipeline: never reset, so stale beats keep flowing after rst_in.
  bit           pv [LAT];
  logic [W-1:0] pd [LAT];

  // Reference model state
  logic [W-1:0] q[$];
  int  issued = 0, popped = 0, drain_left = 0, tot_fire = 0, tot_pop = 0;
  bit  known = 0, err_exp = 0;

  // Values seen before the edge of the most recent cycle
  int           snap_credits;
  bit           snap_ready, snap_mvalid, snap_err;
  logic [W-1:0] snap_mdata;

  typedef struct {
    bit rst; bit sv; logic [W-1:0] sd; bit mr;
    bit chk; bit ready; int credits; bit mvalid; logic [W-1:0] mdata;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit sv, input logic [W-1:0] sd, input bit mr,
                       input bit inj, input bit inj_v, input logic [W-1:0] inj_d);
    bit run_exp, ready_exp, fire_exp, pop_exp, full_before, iv;
    int credits_exp;
    logic [W-1:0] id, tmp;
    rst_in       = rst;
    s_valid_in   = sv;
    s_data_in    = sd;
    m_ready_in   = mr;
    ret_valid_in = inj ? inj_v : pv[LAT-1];
    ret_data_in  = inj ? inj_d : pd[LAT-1];
    #1;
    run_exp     = (drain_left == 0);
    credits_exp = D - (issued - popped);
    ready_exp   = run_exp && (credits_exp != 0);
    fire_exp    = sv && ready_exp;
    pop_exp     = mr && (q.size() != 0);
    snap_ready   = s_ready_out;
    snap_credits = int'(credits_out);
    snap_mvalid  = m_valid_out;
    snap_mdata   = m_data_out;
    snap_err     = err_out;
    if (known) begin
      chk("s_ready", int'(s_ready_out), int'(ready_exp));
      chk("credits", int'(credits_out), credits_exp);
      chk("m_valid", int'(m_valid_out), int'(q.size() != 0));
      if (q.size() != 0) chk("m_data", int'(m_data_out), int'(q[0]));
      chk("issue_valid", int'(issue_valid_out), int'(fire_exp));
      if (fire_exp) chk("issue_data", int'(issue_data_out), int'(sd));
      chk("err", int'(err_out), int'(err_exp));
    end
    iv = issue_valid_out;
    id = issue_data_out;
    if (rst) begin
      q.delete();
      issued = 0; popped = 0; drain_left = LAT; err_exp = 0; known = 1;
    end else if (known) begin
      if (run_exp) begin
        full_before = (q.size() == D);
`ifdef PIPE_SCHED_LATENCY_CHECK_EN
        if (ret_valid_in != pv[LAT-1]) err_exp = 1;
`endif
        if (pop_exp) begin
          tmp = q.pop_front();
          if (credits_exp == D) err_exp = 1;
          popped++; tot_pop++;
        end
        if (ret_valid_in) begin
          if (full_before && !pop_exp) err_exp = 1;
          else q.push_back(ret_data_in);
        end
        if (fire_exp) begin issued++; tot_fire++; end
      end else begin
        drain_left--;
      end
    end
    @(posedge clk_in);
    for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    pv[0] = iv;
    pd[0] = id;
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic step(input bit rst, input bit sv, input logic [W-1:0] sd, input bit mr);
    cycle(rst, sv, sd, mr, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int base_fire, base_pop, n;
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = '0; end

    // Reset, drain, then fill to 4 credits with the sink stalled, then release it.
    tbl[0]  = '{1,0,16'h0,0, 0, 0,0,0,16'h0};
    tbl[1]  = '{0,0,16'h0,0, 1, 0,4,0,16'h0};
    tbl[2]  = '{0,0,16'h0,0, 1, 0,4,0,16'h0};
    tbl[3]  = '{0,0,16'h0,0, 1, 0,4,0,16'h0};
    tbl[4]  = '{0,1,16'h1,0, 1, 1,4,0,16'h0};
    tbl[5]  = '{0,1,16'h2,0, 1, 1,3,0,16'h0};
    tbl[6]  = '{0,1,16'h3,0, 1, 1,2,0,16'h0};
    tbl[7]  = '{0,1,16'h4,0, 1, 1,1,0,16'h0};
    tbl[8]  = '{0,1,16'h5,0, 1, 0,0,1,16'h1};
    tbl[9]  = '{0,1,16'h5,0, 1, 0,0,1,16'h1};
    tbl[10] = '{0,1,16'h5,0, 1, 0,0,1,16'h1};
    tbl[11] = '{0,1,16'h5,0, 1, 0,0,1,16'h1};
    tbl[12] = '{0,1,16'h5,1, 1, 0,0,1,16'h1};
    tbl[13] = '{0,1,16'h5,1, 1, 1,1,1,16'h2};
    tbl[14] = '{0,1,16'h6,1, 1, 1,1,1,16'h3};
    tbl[15] = '{0,1,16'h7,1, 1, 1,1,1,16'h4};
    tbl[16] = '{0,1,16'h8,1, 1, 1,1,0,16'h0};
    tbl[17] = '{0,0,16'h0,1, 1, 0,0,1,16'h5};
    tbl[18] = '{0,0,16'h0,1, 1, 1,1,1,16'h6};
    tbl[19] = '{0,0,16'h0,1, 1, 1,2,1,16'h7};
    tbl[20] = '{0,0,16'h0,1, 1, 1,3,1,16'h8};
    tbl[21] = '{0,0,16'h0,1, 1, 1,4,0,16'h0};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      if (tbl[i].chk) begin
        chk("tbl_ready", int'(snap_ready), int'(tbl[i].ready));
        chk("tbl_credits", snap_credits, tbl[i].credits);
        chk("tbl_mvalid", int'(snap_mvalid), int'(tbl[i].mvalid));
        if (tbl[i].mvalid) chk("tbl_mdata", int'(snap_mdata), int'(tbl[i].mdata));
        chk("tbl_err", int'(snap_err), 0);
      end
    end

    // Continuous streaming of 20 beats with the sink always ready; FIFO pointers wrap.
    base_fire = tot_fire;
    base_pop  = tot_pop;
    for (int i = 0; i < 60; i++) begin
      n = tot_fire - base_fire;
      step(0, n < 20, 16'h0100 + 16'(n), 1);
    end
    chk("stream_pops", tot_pop - base_pop, 20);
    step(0, 0, 16'h0, 1);
    chk("stream_credits", snap_credits, D);

    // Full FIFO: write and pop together, then a write with no pop overflows.
    for (int i = 0; i < 9; i++) step(0, 1, 16'h0400 + 16'(i), 0);
    cycle(0, 0, 16'h0, 1, 1, 1, 16'hBEEF);
    chk("full_credits", snap_credits, 0);
    chk("full_mvalid", int'(snap_mvalid), 1);
    cycle(0, 0, 16'h0, 0, 1, 1, 16'hDEAD);
    chk("full_head", int'(snap_mdata), 16'h0401);
`ifndef PIPE_SCHED_LATENCY_CHECK_EN
    chk("full_wr_pop_err", int'(snap_err), 0);
`endif
    step(0, 0, 16'h0, 0);
    chk("overflow_err", int'(snap_err), 1);

    // Reset with beats in flight: their returns land in DRAIN and are dropped.
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < LAT; i++) step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0500, 0);
    step(0, 1, 16'h0501, 0);
    step(1, 0, 16'h0, 1);
    for (int i = 0; i < LAT; i++) step(0, 1, 16'h0502, 1);
    step(0, 0, 16'h0, 1);
    chk("rst_flight_credits", snap_credits, D);
    chk("rst_flight_mvalid", int'(snap_mvalid), 0);
    chk("rst_flight_err", int'(snap_err), 0);

`ifdef PIPE_SCHED_LATENCY_CHECK_EN
    // Return injected one cycle ahead of the real one.
    step(0, 1, 16'h0600, 0);
    step(0, 0, 16'h0, 0);
    cycle(0, 0, 16'h0, 0, 1, 1, 16'h0666);
    step(0, 0, 16'h0, 0);
    chk("early_ret_err", int'(snap_err), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0, 0);
      chk("early_ret_sticky", int'(snap_err), 1);
    end
    step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    chk("early_ret_cleared", int'(snap_err), 0);
`endif

    // Randomized traffic with occasional resets, checked every cycle by the model.
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           16'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
